// File: rtl/antares_reg_file_mp_if.sv
// Bus between decode/writeback and the Antares GPR file.
// The master drives addresses and write data; the slave returns read data and readiness.
interface antares_reg_file_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic [NUM_READ*ADDR_WIDTH-1:0] gpr_ra;
    logic [NUM_READ*DATA_WIDTH-1:0] gpr_rd;
    logic [ADDR_WIDTH-1:0]          gpr_wa;
    logic [DATA_WIDTH-1:0]          gpr_wd;
    logic                           gpr_we;
    logic                           gpr_ready;

    modport master (
        output gpr_ra,
        output gpr_wa,
        output gpr_wd,
        output gpr_we,
        input  gpr_rd,
        input  gpr_ready
    );

    modport slave (
        input  gpr_ra,
        input  gpr_wa,
        input  gpr_wd,
        input  gpr_we,
        output gpr_rd,
        output gpr_ready
    );
endinterface

// File: rtl/antares_reg_file_mp.sv
// Antares GPR file: one write port, NUM_READ combinational read ports, self-clearing after reset.
// Optional hard-wired zero entry 0 and optional write-to-read bypass.
module antares_reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    antares_reg_file_mp_if.slave       bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_idx;
    logic [ADDR_WIDTH-1:0]   clr_idx_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    wr_ok;
    logic [ADDR_WIDTH-1:0]   ra;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_all;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // The sweep ends on the edge that clears the last entry; clr_idx wraps back to 0 there.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            CLEAR: begin
                clr_idx_nxt = clr_idx + 1'b1;
                if (&clr_idx) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    always_comb begin
        wr_ok = rst_n && (state == RUN) && bus.gpr_we;
        if ((ZERO_REG != 0) && (bus.gpr_wa == '0)) begin
            wr_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (wr_ok) begin
                mem[bus.gpr_wa] <= bus.gpr_wd;
            end
        end
    end

    always_comb begin
        rd_all = '0;
        ra     = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            ra = bus.gpr_ra[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (state == CLEAR) begin
                rd_all[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_all[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if ((BYPASS != 0) && wr_ok && (ra == bus.gpr_wa)) begin
                rd_all[k*DATA_WIDTH +: DATA_WIDTH] = bus.gpr_wd;
            end else begin
                rd_all[k*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
            end
        end
    end

    assign bus.gpr_rd    = rd_all;
    assign bus.gpr_ready = (state == RUN);
endmodule

// File: tb/tb_antares_reg_file_mp.sv
// Directed bench for antares_reg_file_mp: three instances cover ZERO_REG/BYPASS/NUM_READ variants.
// Stimulus pushes expected values into a queue; a negedge monitor pops and compares them.
module tb_antares_reg_file_mp;
    logic clk;
    logic rst_n;

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] exp;
        string       name;
    } check_t;

    check_t sb[$];
    int     n_checks;
    int     n_fail;

    antares_reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus_a ();
    antares_reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus_b ();
    antares_reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(3)) bus_c ();

    antares_reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    antares_reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(0), .BYPASS(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    antares_reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(3), .ZERO_REG(1), .BYPASS(0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] get_actual(input int dut, input int port);
        logic [31:0] v;
        v = '0;
        case (dut)
            0: v = (port < 0) ? {31'b0, bus_a.gpr_ready} : bus_a.gpr_rd[port*32 +: 32];
            1: v = (port < 0) ? {31'b0, bus_b.gpr_ready} : bus_b.gpr_rd[port*32 +: 32];
            default: v = (port < 0) ? {31'b0, bus_c.gpr_ready} : bus_c.gpr_rd[port*32 +: 32];
        endcase
        return v;
    endfunction

    // Monitor: compares every pending expectation against what the DUTs present mid-cycle.
    always @(negedge clk) begin
        check_t c;
        logic [31:0] act;
        while (sb.size() > 0) begin
            c   = sb.pop_front();
            act = get_actual(c.dut, c.port);
            n_checks++;
            if (act !== c.exp) begin
                n_fail++;
                $display("[TB] FAIL %s: got %h, expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic expect_val(input int dut, input int port, input logic [31:0] exp, input string name);
        check_t c;
        c.dut  = dut;
        c.port = port;
        c.exp  = exp;
        c.name = name;
        sb.push_back(c);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int dut, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        case (dut)
            0: begin bus_a.gpr_we = we; bus_a.gpr_wa = wa; bus_a.gpr_wd = wd; end
            1: begin bus_b.gpr_we = we; bus_b.gpr_wa = wa; bus_b.gpr_wd = wd; end
            default: begin bus_c.gpr_we = we; bus_c.gpr_wa = wa; bus_c.gpr_wd = wd; end
        endcase
    endtask

    task automatic clear_sweep(input bit inject, input string tag);
        for (int e = 1; e <= 32; e++) begin
            next_cycle();
            if (inject && e == 10) begin
                apply_stimulus(0, 1'b0, 5'd0, 32'h0);
            end
            for (int d = 0; d < 3; d++) begin
                expect_val(d, -1, {31'b0, e == 32}, $sformatf("%s ready dut%0d edge%0d", tag, d, e));
            end
            if (inject && e == 9) begin
                apply_stimulus(0, 1'b1, 5'd3, 32'h12345678);
                bus_a.gpr_ra[4:0] = 5'd3;
                expect_val(0, 0, 32'h0, "clear-phase read no bypass");
            end
            check_output();
        end
    endtask

    task automatic read_all_zero_a(input string tag);
        for (int addr = 0; addr < 32; addr++) begin
            bus_a.gpr_ra = {5'(31 - addr), 5'(addr)};
            expect_val(0, 0, 32'h0, $sformatf("%s a.p0 addr%0d", tag, addr));
            expect_val(0, 1, 32'h0, $sformatf("%s a.p1 addr%0d", tag, 31 - addr));
            check_output();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus_a.gpr_ra = '0; bus_b.gpr_ra = '0; bus_c.gpr_ra = '0;
        for (int d = 0; d < 3; d++) apply_stimulus(d, 1'b0, 5'd0, 32'h0);

        next_cycle();
        next_cycle();
        for (int d = 0; d < 3; d++) expect_val(d, -1, 32'h0, $sformatf("reset ready dut%0d", d));
        check_output();
        rst_n = 1'b1;
        clear_sweep(1'b1, "sweep1");

        read_all_zero_a("init");
        for (int addr = 0; addr < 32; addr++) begin
            bus_c.gpr_ra = {5'(addr), 5'(31 - addr), 5'(addr)};
            for (int k = 0; k < 3; k++) expect_val(2, k, 32'h0, $sformatf("init c.p%0d addr%0d", k, addr));
            check_output();
        end

        // Bypass on a and b: same-cycle read returns write data, stored after the edge
        next_cycle();
        apply_stimulus(0, 1'b1, 5'd5, 32'hDEADBEEF);
        bus_a.gpr_ra = {5'd6, 5'd5};
        expect_val(0, 0, 32'hDEADBEEF, "bypass rd0");
        expect_val(0, 1, 32'h0, "bypass other port");
        check_output();
        next_cycle();
        apply_stimulus(0, 1'b0, 5'd0, 32'h0);
        bus_a.gpr_ra = {5'd5, 5'd0};
        expect_val(0, 1, 32'hDEADBEEF, "stored rd1");
        expect_val(0, 0, 32'h0, "zero reg read");
        check_output();

        // Entry 0 write: ignored on a, normal register on b
        next_cycle();
        apply_stimulus(0, 1'b1, 5'd0, 32'hFFFFFFFF);
        apply_stimulus(1, 1'b1, 5'd0, 32'hFFFFFFFF);
        bus_a.gpr_ra = '0;
        bus_b.gpr_ra = '0;
        expect_val(0, 0, 32'h0, "zreg before edge");
        expect_val(1, 0, 32'hFFFFFFFF, "nozreg bypass");
        check_output();
        next_cycle();
        apply_stimulus(0, 1'b0, 5'd0, 32'h0);
        apply_stimulus(1, 1'b0, 5'd0, 32'h0);
        expect_val(0, 0, 32'h0, "zreg after edge");
        expect_val(1, 0, 32'hFFFFFFFF, "nozreg after edge");
        expect_val(1, 1, 32'hFFFFFFFF, "nozreg port1");
        check_output();

        // No-bypass instance with three ports
        next_cycle();
        apply_stimulus(2, 1'b1, 5'd7, 32'h11111111);
        next_cycle();
        apply_stimulus(2, 1'b1, 5'd9, 32'h22222222);
        next_cycle();
        apply_stimulus(2, 1'b0, 5'd0, 32'h0);
        bus_c.gpr_ra = {5'd7, 5'd9, 5'd7};
        expect_val(2, 0, 32'h11111111, "c diff p0");
        expect_val(2, 1, 32'h22222222, "c diff p1");
        expect_val(2, 2, 32'h11111111, "c diff p2");
        check_output();
        next_cycle();
        apply_stimulus(2, 1'b1, 5'd7, 32'hAAAA5555);
        bus_c.gpr_ra = {5'd7, 5'd7, 5'd7};
        for (int k = 0; k < 3; k++) expect_val(2, k, 32'h11111111, $sformatf("c old p%0d", k));
        check_output();
        next_cycle();
        apply_stimulus(2, 1'b0, 5'd0, 32'h0);
        for (int k = 0; k < 3; k++) expect_val(2, k, 32'hAAAA5555, $sformatf("c new p%0d", k));
        check_output();

        // Fill a, then reset mid-run with a write pending
        for (int i = 1; i < 32; i++) begin
            next_cycle();
            apply_stimulus(0, 1'b1, 5'(i), 32'(i) * 32'h01010101);
        end
        next_cycle();
        apply_stimulus(0, 1'b0, 5'd0, 32'h0);
        bus_a.gpr_ra = {5'd31, 5'd1};
        expect_val(0, 0, 32'h01010101, "fill entry1");
        expect_val(0, 1, 32'h1F1F1F1F, "fill entry31");
        check_output();
        bus_a.gpr_ra = {5'd16, 5'd5};
        expect_val(0, 0, 32'h05050505, "fill entry5");
        expect_val(0, 1, 32'h10101010, "fill entry16");
        check_output();

        next_cycle();
        rst_n = 1'b0;
        apply_stimulus(0, 1'b1, 5'd2, 32'hCAFEF00D);
        bus_a.gpr_ra = {5'd0, 5'd2};
        expect_val(0, 0, 32'h02020202, "no bypass under reset");
        expect_val(0, -1, 32'h1, "ready before reset edge");
        check_output();
        next_cycle();
        apply_stimulus(0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        clear_sweep(1'b0, "sweep2");

        read_all_zero_a("post-reset");
        bus_b.gpr_ra = '0;
        bus_c.gpr_ra = {5'd0, 5'd9, 5'd7};
        expect_val(1, 0, 32'h0, "b entry0 recleared");
        expect_val(2, 0, 32'h0, "c entry7 recleared");
        expect_val(2, 1, 32'h0, "c entry9 recleared");
        check_output();

        check_output();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
